kp_key_fifo: RTL and testbench

KP_KEY_FIFO -- requirements
Module: kp_key_fifo

---
 rtl/kp_pkg.sv | 6 +
 rtl/kp_key_fifo_if.sv | 20 ++
 rtl/kp_sync.sv | 22 ++
 rtl/kp_key_fifo.sv | 95 +++++++++
 tb/tb_kp_key_fifo.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/kp_pkg.sv
// Shared defaults for the keypad key FIFO and its helpers.
package kp_pkg;
  localparam int KP_DATA_W   = 4;
  localparam int KP_DEPTH    = 4;
  localparam int KP_DEBOUNCE = 3;
endpackage

// File: rtl/kp_key_fifo_if.sv
// Scanner/consumer side signals of the key FIFO, grouped for benches and integration.
interface kp_key_fifo_if
  import kp_pkg::*;
#(
  parameter int DATA_W = KP_DATA_W,
  parameter int DEPTH  = KP_DEPTH
);
  logic                     ena;
  logic [DATA_W-1:0]        d;
  logic                     rd;
  logic                     clr_ovf;
  logic [DATA_W-1:0]        d_l;
  logic                     valid;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;

  modport master (output ena, d, rd, clr_ovf, input d_l, valid, full, count, ovf);
  modport slave  (input ena, d, rd, clr_ovf, output d_l, valid, full, count, ovf);
endinterface

// File: rtl/kp_sync.sv
// Two-flop synchroniser for a single asynchronous level.
module kp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/kp_key_fifo.sv
// Keypad key FIFO: debounces the scanner strobe, queues key codes on release,
// and tracks a sticky overflow flag when a keypress has to be dropped.
module kp_key_fifo
  import kp_pkg::*;
#(
  parameter int DATA_W   = KP_DATA_W,
  parameter int DEPTH    = KP_DEPTH,
  parameter int DEBOUNCE = KP_DEBOUNCE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [DATA_W-1:0]      d,
  input  logic                   rd,
  input  logic                   clr_ovf,
  output logic [DATA_W-1:0]      d_l,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(DEBOUNCE + 1);

  logic              w_s2;
  logic              r_s3;
  logic [HW-1:0]     r_hcnt;
  logic [DATA_W-1:0] r_d_hold;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              w_press;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  kp_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ena),
    .o_q   (w_s2)
  );

  // Only a release after at least DEBOUNCE synchronised high cycles counts.
  assign w_press = r_s3 && !w_s2 && (r_hcnt == HW'(DEBOUNCE));
  assign valid   = (r_count != '0);
  assign full    = (r_count == CW'(DEPTH));
  assign w_pop   = rd && valid;
  assign w_push  = w_press && (!full || w_pop);
  assign w_drop  = w_press && full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3     <= 1'b0;
      r_hcnt   <= '0;
      r_d_hold <= '0;
    end else begin
      r_s3 <= w_s2;
      if (w_s2) begin
        r_d_hold <= d;
        if (r_hcnt != HW'(DEBOUNCE)) r_hcnt <= r_hcnt + HW'(1);
      end else begin
        r_hcnt <= '0;
      end
    end
  end

  // Storage is deliberately left unreset; d_l is meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_d_hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign d_l   = r_mem[r_rptr];
  assign count = r_count;
  assign ovf   = r_ovf;
endmodule

// File: tb/tb_kp_key_fifo.sv
// Self-checking bench for kp_key_fifo against a queue-based keypress model.
module tb_kp_key_fifo;
  import kp_pkg::*;

  localparam int DW  = KP_DATA_W;
  localparam int DEP = KP_DEPTH;
  localparam int DEB = KP_DEBOUNCE;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   q[$];
  bit   m_ovf;

  kp_key_fifo_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  kp_key_fifo #(.DATA_W(DW), .DEPTH(DEP), .DEBOUNCE(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .d       (bus.d),
    .rd      (bus.rd),
    .clr_ovf (bus.clr_ovf),
    .d_l     (bus.d_l),
    .valid   (bus.valid),
    .full    (bus.full),
    .count   (bus.count),
    .ovf     (bus.ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  // Keypress model: pop applies first, then a push is accepted if there is room.
  task automatic model_step(input bit push_req, input bit pop_req);
    bit was_full;
    was_full = (q.size() == DEP);
    if (pop_req && q.size() > 0) begin
      void'(q.pop_front());
      if (push_req) q.push_back(-1);
    end else if (push_req) begin
      if (was_full) m_ovf = 1'b1;
      else q.push_back(-1);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(q.size() > 0));
    chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DEP));
    chk({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
    if (q.size() > 0) chk({tag, ".d_l"}, 32'(bus.d_l), 32'(q[0]));
  endtask

  // Press with ena high for hi cycles; optionally pop on the edge that would push.
  task automatic press(input string tag, input int code, input int hi, input bit rd_at);
    bit pushes;
    pushes = (hi >= DEB);
    bus.d   = DW'(code);
    bus.ena = 1'b1;
    repeat (hi) @(posedge clk);
    #1 bus.ena = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, ".early"}, 32'(bus.count), 32'(q.size()));
    bus.rd = rd_at;
    if (rd_at && q.size() > 0) chk({tag, ".pop_head"}, 32'(bus.d_l), 32'(q[0]));
    @(posedge clk); #1;
    bus.rd = 1'b0;
    model_step(pushes, rd_at);
    if (pushes && (q.size() > 0) && q[q.size()-1] == -1) q[q.size()-1] = code;
    check_state(tag);
  endtask

  task automatic pop(input string tag);
    bus.rd = 1'b1;
    if (q.size() > 0) chk({tag, ".head"}, 32'(bus.d_l), 32'(q[0]));
    @(posedge clk); #1;
    bus.rd = 1'b0;
    model_step(1'b0, 1'b1);
    check_state(tag);
  endtask

  task automatic clear_ovf(input string tag);
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1;
    bus.clr_ovf = 1'b0;
    m_ovf = 1'b0;
    check_state(tag);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_ovf = 1'b0;
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.d = '0; bus.rd = 1'b0; bus.clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single press, with latency checked inside press().
    press("single", 'hA, 5, 1'b0);
    pop("single_pop");

    press("glitch", 'h7, 2, 1'b0);
    press("glitch1", 'h3, 1, 1'b0);

    // Overflow: fifth press is dropped.
    for (int i = 1; i <= 5; i++) press("ovf_push", i, DEB, 1'b0);
    clear_ovf("ovf_clr");
    for (int i = 0; i < 4; i++) pop("ovf_pop");
    pop("empty_pop");

    // Coincident push and pop while full.
    for (int i = 6; i <= 9; i++) press("full_fill", i, 4, 1'b0);
    press("full_coinc", 'hB, 3, 1'b1);
    for (int i = 0; i < 4; i++) pop("full_drain");

    // Coincident push and pop while empty: push only.
    press("empty_coinc", 'hC, 3, 1'b1);
    pop("empty_coinc_pop");

    // Reset mid-press with two entries queued.
    press("rst_fill", 'h1, 3, 1'b0);
    press("rst_fill", 'h2, 3, 1'b0);
    bus.ena = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0;
    check_state("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.ena = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_state("rst_after");

    // Wrap-around with alternating press/pop.
    for (int i = 0; i < 10; i++) begin
      press("wrap_push", i, 3, 1'b0);
      chk("wrap_max", 32'(bus.count <= 1), 32'd1);
      pop("wrap_pop");
    end

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      press("rnd_press", int'($urandom_range(0, 15)), int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
      else if (sel < 9) pop("rnd_pop");
      else              clear_ovf("rnd_clr");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
